// File: rtl/guess_pkg.sv
// Shared types and constants for the hits/blows code-guessing engine.
package guess_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    GUESS  = 3'd2,
    RESULT = 3'd3,
    WIN    = 3'd4,
    LOSE   = 3'd5
  } state_e;

  typedef logic [3:0] digit_t;

  localparam digit_t SYM_A    = 4'd10;
  localparam digit_t SYM_B    = 4'd11;
  localparam digit_t SYM_DASH = 4'd12;

  // One up/down step on a digit, either saturating or wrapping modulo radix.
  function automatic digit_t step_digit(digit_t d, logic up, int radix, logic wrap);
    if (up) begin
      if (d == digit_t'(radix - 1)) return wrap ? digit_t'(0) : d;
      return d + 4'd1;
    end
    if (d == 4'd0) return wrap ? digit_t'(radix - 1) : d;
    return d - 4'd1;
  endfunction

endpackage

// File: rtl/code_guess_core_if.sv
// Button/tick inputs and display/status outputs of the guessing engine.
interface code_guess_core_if #(
  parameter int N_DIGITS = 4
);
  localparam int CUR_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                  tick;
  logic                  btn_next;
  logic                  btn_back;
  logic                  btn_up;
  logic                  btn_down;
  logic [4*N_DIGITS-1:0] disp;
  logic [CUR_W-1:0]      cursor;
  logic                  cursor_valid;
  logic [2:0]            state;
  logic [3:0]            hits;
  logic [3:0]            blows;
  logic [3:0]            tries;
  logic                  flash;

  modport master (
    output tick, btn_next, btn_back, btn_up, btn_down,
    input  disp, cursor, cursor_valid, state, hits, blows, tries, flash
  );

  modport slave (
    input  tick, btn_next, btn_back, btn_up, btn_down,
    output disp, cursor, cursor_valid, state, hits, blows, tries, flash
  );

endinterface

// File: rtl/guess_scorer.sv
// Combinational hits/blows scoring of a guess against the secret.
module guess_scorer
  import guess_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  digit_t [N_DIGITS-1:0] guess_i,
  input  digit_t [N_DIGITS-1:0] secret_i,
  output logic   [3:0]          hits_o,
  output logic   [3:0]          blows_o
);

  logic [N_DIGITS-1:0] hit_v;
  logic [N_DIGITS-1:0] blow_v;

  // A blow is counted per guess position, so a repeated guess digit can score twice.
  always_comb begin
    hit_v   = '0;
    blow_v  = '0;
    hits_o  = '0;
    blows_o = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      hit_v[i] = (guess_i[i] == secret_i[i]);
      for (int j = 0; j < N_DIGITS; j++) begin
        if (j != i && !hit_v[i] && guess_i[i] == secret_i[j]) blow_v[i] = 1'b1;
      end
      hits_o  = hits_o  + {3'b000, hit_v[i]};
      blows_o = blows_o + {3'b000, blow_v[i]};
    end
  end

endmodule

// File: rtl/code_guess_core.sv
// Game FSM: digit editing, secret latch, scoring, try limit and win flashing.
module code_guess_core
  import guess_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int RADIX       = 10,
  parameter int MAX_TRIES   = 8,
  parameter int WRAP        = 0,
  parameter int FLASH_TICKS = 5
) (
  input  logic              clk,
  input  logic              rst,
  code_guess_core_if.slave  bus
);

  localparam int CUR_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FT_W  = (FLASH_TICKS > 0) ? $clog2(FLASH_TICKS + 1) : 1;
  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(N_DIGITS - 1);

  state_e                state_q,  state_d;
  digit_t [N_DIGITS-1:0] digits_q, digits_d;
  digit_t [N_DIGITS-1:0] secret_q, secret_d;
  logic   [CUR_W-1:0]    cursor_q, cursor_d;
  logic   [3:0]          hits_q,   hits_d;
  logic   [3:0]          blows_q,  blows_d;
  logic   [3:0]          tries_q,  tries_d;
  logic                  flash_q,  flash_d;
  logic   [FT_W-1:0]     ticks_q,  ticks_d;

  logic   [3:0]          score_hits, score_blows, tries_inc;
  logic                  do_next, do_back, do_up, do_down, to_idle;
  digit_t [N_DIGITS-1:0] disp_c;

  guess_scorer #(.N_DIGITS(N_DIGITS)) u_scorer (
    .guess_i  (digits_q),
    .secret_i (secret_q),
    .hits_o   (score_hits),
    .blows_o  (score_blows)
  );

  // Only the highest-priority coincident button acts.
  assign do_next   = bus.btn_next;
  assign do_back   = bus.btn_back & ~bus.btn_next;
  assign do_up     = bus.btn_up   & ~bus.btn_next & ~bus.btn_back;
  assign do_down   = bus.btn_down & ~bus.btn_next & ~bus.btn_back & ~bus.btn_up;
  assign tries_inc = tries_q + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      digits_q <= '0;
      secret_q <= '0;
      cursor_q <= '0;
      hits_q   <= '0;
      blows_q  <= '0;
      tries_q  <= '0;
      flash_q  <= 1'b0;
      ticks_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge next-state values together.
      state_q  <= state_d;
      digits_q <= digits_d;
      secret_q <= secret_d;
      cursor_q <= cursor_d;
      hits_q   <= hits_d;
      blows_q  <= blows_d;
      tries_q  <= tries_d;
      flash_q  <= flash_d;
      ticks_q  <= ticks_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no branch can leave a latch behind.
    state_d  = state_q;
    digits_d = digits_q;
    secret_d = secret_q;
    cursor_d = cursor_q;
    hits_d   = hits_q;
    blows_d  = blows_q;
    tries_d  = tries_q;
    flash_d  = flash_q;
    ticks_d  = ticks_q;
    to_idle  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (do_next) begin
          digits_d = '0;
          cursor_d = CUR_LAST;
          state_d  = SET;
        end
      end

      SET, GUESS: begin
        if (do_next) begin
          if (cursor_q != '0) begin
            cursor_d = cursor_q - CUR_W'(1);
          end else if (state_q == SET) begin
            secret_d = digits_q;
            digits_d = '0;
            cursor_d = CUR_LAST;
            tries_d  = '0;
            state_d  = GUESS;
          end else begin
            // The guess stays in digits_q so WIN can keep showing it.
            hits_d  = score_hits;
            blows_d = score_blows;
            tries_d = tries_inc;
            if (score_hits == 4'(N_DIGITS)) begin
              ticks_d = '0;
              flash_d = 1'b0;
              state_d = WIN;
            end else if (MAX_TRIES != 0 && tries_inc == 4'(MAX_TRIES)) begin
              state_d = LOSE;
            end else begin
              state_d = RESULT;
            end
          end
        end else if (do_back) begin
          if (cursor_q != CUR_LAST) cursor_d = cursor_q + CUR_W'(1);
          else                      to_idle  = 1'b1;
        end else if (do_up || do_down) begin
          digits_d[cursor_q] = step_digit(digits_q[cursor_q], do_up, RADIX, WRAP != 0);
        end
      end

      RESULT: begin
        if (do_next) begin
          digits_d = '0;
          cursor_d = CUR_LAST;
          state_d  = GUESS;
        end else if (do_back) begin
          to_idle = 1'b1;
        end
      end

      // The exit is taken on the cycle after the last counted tick, so that tick still toggles.
      WIN: begin
        if (ticks_q == FT_W'(FLASH_TICKS)) begin
          to_idle = 1'b1;
        end else if (bus.tick) begin
          flash_d = ~flash_q;
          ticks_d = ticks_q + FT_W'(1);
        end
      end

      LOSE: begin
        if (do_next || do_back) to_idle = 1'b1;
      end

      default: to_idle = 1'b1;
    endcase

    if (to_idle) begin
      state_d  = IDLE;
      hits_d   = '0;
      blows_d  = '0;
      tries_d  = '0;
      cursor_d = '0;
      flash_d  = 1'b0;
    end
  end

  // Display decode reads registers only, so no input reaches an output in the same cycle.
  always_comb begin
    disp_c = {N_DIGITS{SYM_DASH}};
    unique case (state_q)
      SET, GUESS, WIN: disp_c = digits_q;
      LOSE:            disp_c = secret_q;
      RESULT: begin
        disp_c[N_DIGITS-1] = hits_q;
        disp_c[N_DIGITS-2] = SYM_A;
        disp_c[N_DIGITS-3] = blows_q;
        disp_c[N_DIGITS-4] = SYM_B;
      end
      default: disp_c = {N_DIGITS{SYM_DASH}};
    endcase
  end

  assign bus.disp         = disp_c;
  assign bus.cursor       = cursor_q;
  assign bus.cursor_valid = (state_q == SET) || (state_q == GUESS);
  assign bus.state        = state_q;
  assign bus.hits         = hits_q;
  assign bus.blows        = blows_q;
  assign bus.tries        = tries_q;
  assign bus.flash        = flash_q;

endmodule

// File: tb/tb_code_guess_core.sv
// Directed bench: four engine configurations share one stimulus stream; each test checks its target.
module tb_code_guess_core;
  import guess_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, bn = 1'b0, bb = 1'b0, bu = 1'b0, bd = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  code_guess_core_if #(.N_DIGITS(4)) if_def  ();
  code_guess_core_if #(.N_DIGITS(4)) if_try  ();
  code_guess_core_if #(.N_DIGITS(4)) if_wrap ();
  code_guess_core_if #(.N_DIGITS(6)) if_wide ();

  assign if_def.tick  = tick; assign if_def.btn_next  = bn; assign if_def.btn_back  = bb;
  assign if_def.btn_up  = bu; assign if_def.btn_down  = bd;
  assign if_try.tick  = tick; assign if_try.btn_next  = bn; assign if_try.btn_back  = bb;
  assign if_try.btn_up  = bu; assign if_try.btn_down  = bd;
  assign if_wrap.tick = tick; assign if_wrap.btn_next = bn; assign if_wrap.btn_back = bb;
  assign if_wrap.btn_up = bu; assign if_wrap.btn_down = bd;
  assign if_wide.tick = tick; assign if_wide.btn_next = bn; assign if_wide.btn_back = bb;
  assign if_wide.btn_up = bu; assign if_wide.btn_down = bd;

  code_guess_core u_def  (.clk(clk), .rst(rst), .bus(if_def));
  code_guess_core #(.MAX_TRIES(2)) u_try (.clk(clk), .rst(rst), .bus(if_try));
  code_guess_core #(.RADIX(6), .WRAP(1)) u_wrap (.clk(clk), .rst(rst), .bus(if_wrap));
  code_guess_core #(.N_DIGITS(6)) u_wide (.clk(clk), .rst(rst), .bus(if_wide));

  task automatic press(input logic n, input logic b, input logic u, input logic d);
    @(negedge clk);
    bn = n; bb = b; bu = u; bd = d;
    @(negedge clk);
    bn = 1'b0; bb = 1'b0; bu = 1'b0; bd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; bn = 1'b0; bb = 1'b0; bu = 1'b0; bd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Enters a code from the leftmost position down; nibble i of code is position i.
  task automatic enter_code(input int n, input logic [31:0] code);
    int v;
    for (int c = n - 1; c >= 0; c--) begin
      v = int'(code[4*c +: 4]);
      repeat (v) press(1'b0, 1'b0, 1'b1, 1'b0);
      press(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (if_def.state !== 3'(IDLE)) begin bad++; $display("FAIL reset_state got=%0d want=%0d", if_def.state, IDLE); end
    total++; if (if_def.disp !== 16'hCCCC) begin bad++; $display("FAIL reset_disp got=%h want=cccc", if_def.disp); end
    total++; if (if_def.cursor !== 2'd0) begin bad++; $display("FAIL reset_cursor got=%0d want=0", if_def.cursor); end
    total++; if (if_def.cursor_valid !== 1'b0) begin bad++; $display("FAIL reset_cvalid got=%b want=0", if_def.cursor_valid); end
    total++; if ({if_def.hits, if_def.blows, if_def.tries} !== 12'h000) begin bad++; $display("FAIL reset_score got=%h want=000", {if_def.hits, if_def.blows, if_def.tries}); end
    total++; if (if_def.flash !== 1'b0) begin bad++; $display("FAIL reset_flash got=%b want=0", if_def.flash); end
  endtask

  task automatic test_win();
    int   toggles;
    logic prev;
    bit   done;
    do_reset();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    enter_code(4, 32'h1234);
    total++; if (if_def.state !== 3'(GUESS) || if_def.cursor !== 2'd3 || if_def.disp !== 16'h0000)
      begin bad++; $display("FAIL win_enter_guess got=%0d/%0d/%h want=2/3/0000", if_def.state, if_def.cursor, if_def.disp); end
    enter_code(4, 32'h1234);
    total++; if (if_def.state !== 3'(WIN)) begin bad++; $display("FAIL win_state got=%0d want=4", if_def.state); end
    total++; if (if_def.hits !== 4'd4 || if_def.blows !== 4'd0 || if_def.tries !== 4'd1)
      begin bad++; $display("FAIL win_score got=%0d/%0d/%0d want=4/0/1", if_def.hits, if_def.blows, if_def.tries); end
    total++; if (if_def.disp !== 16'h1234 || if_def.flash !== 1'b0)
      begin bad++; $display("FAIL win_disp got=%h/%b want=1234/0", if_def.disp, if_def.flash); end
    toggles = 0; done = 1'b0; prev = if_def.flash;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (if_def.state === 3'(IDLE)) done = 1'b1;
      else if (if_def.flash !== prev) toggles++;
      prev = if_def.flash;
      tick = (cyc % 20 == 19);
      bb   = (cyc == 30);
    end
    tick = 1'b0; bb = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL win_timeout got=state%0d want=idle", if_def.state); end
    total++; if (toggles != 5) begin bad++; $display("FAIL win_toggles got=%0d want=5", toggles); end
    total++; if (if_def.flash !== 1'b0 || if_def.disp !== 16'hCCCC || if_def.tries !== 4'd0)
      begin bad++; $display("FAIL win_exit got=%b/%h/%0d want=0/cccc/0", if_def.flash, if_def.disp, if_def.tries); end
  endtask

  task automatic test_result();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    enter_code(4, 32'h1234);
    enter_code(4, 32'h4231);
    total++; if (if_def.state !== 3'(RESULT) || if_def.cursor_valid !== 1'b0)
      begin bad++; $display("FAIL result_state got=%0d/%b want=3/0", if_def.state, if_def.cursor_valid); end
    total++; if (if_def.hits !== 4'd2 || if_def.blows !== 4'd2 || if_def.tries !== 4'd1)
      begin bad++; $display("FAIL result_score got=%0d/%0d/%0d want=2/2/1", if_def.hits, if_def.blows, if_def.tries); end
    total++; if (if_def.disp !== 16'h2A2B) begin bad++; $display("FAIL result_disp got=%h want=2a2b", if_def.disp); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (if_def.state !== 3'(GUESS) || if_def.disp !== 16'h0000 || if_def.cursor !== 2'd3 || if_def.cursor_valid !== 1'b1)
      begin bad++; $display("FAIL result_next got=%0d/%h/%0d want=2/0000/3", if_def.state, if_def.disp, if_def.cursor); end
    total++; if (if_def.hits !== 4'd2 || if_def.tries !== 4'd1)
      begin bad++; $display("FAIL result_hold got=%0d/%0d want=2/1", if_def.hits, if_def.tries); end
  endtask

  task automatic test_lose();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    enter_code(4, 32'h1234);
    enter_code(4, 32'h4231);
    total++; if (if_try.state !== 3'(RESULT) || if_try.tries !== 4'd1)
      begin bad++; $display("FAIL lose_first got=%0d/%0d want=3/1", if_try.state, if_try.tries); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    enter_code(4, 32'h5678);
    total++; if (if_try.state !== 3'(LOSE) || if_try.disp !== 16'h1234 || if_try.tries !== 4'd2)
      begin bad++; $display("FAIL lose_state got=%0d/%h/%0d want=5/1234/2", if_try.state, if_try.disp, if_try.tries); end
    total++; if (if_def.state !== 3'(RESULT) || if_def.tries !== 4'd2)
      begin bad++; $display("FAIL lose_unlimited got=%0d/%0d want=3/2", if_def.state, if_def.tries); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (if_try.state !== 3'(IDLE) || if_try.tries !== 4'd0 || if_try.disp !== 16'hCCCC)
      begin bad++; $display("FAIL lose_back got=%0d/%0d/%h want=0/0/cccc", if_try.state, if_try.tries, if_try.disp); end
  endtask

  task automatic test_edit_limits();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (if_def.disp !== 16'h9000) begin bad++; $display("FAIL edit_saturate_hi got=%h want=9000", if_def.disp); end
    total++; if (if_wrap.disp !== 16'h0000) begin bad++; $display("FAIL edit_wrap_hi got=%h want=0000", if_wrap.disp); end
    do_reset();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (if_wrap.disp !== 16'h5000) begin bad++; $display("FAIL edit_wrap_lo got=%h want=5000", if_wrap.disp); end
    total++; if (if_def.disp !== 16'h0000) begin bad++; $display("FAIL edit_saturate_lo got=%h want=0000", if_def.disp); end
  endtask

  task automatic test_coincident();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    total++; if (if_def.cursor !== 2'd2 || if_def.disp !== 16'h0000)
      begin bad++; $display("FAIL coinc_next_up got=%0d/%h want=2/0000", if_def.cursor, if_def.disp); end
    press(1'b0, 1'b0, 1'b1, 1'b1);
    total++; if (if_def.disp !== 16'h0100) begin bad++; $display("FAIL coinc_up_down got=%h want=0100", if_def.disp); end
    press(1'b0, 1'b1, 1'b0, 1'b1);
    total++; if (if_def.cursor !== 2'd3 || if_def.disp !== 16'h0100)
      begin bad++; $display("FAIL coinc_back_down got=%0d/%h want=3/0100", if_def.cursor, if_def.disp); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    total++; if (if_def.state !== 3'(IDLE) || if_def.disp !== 16'hCCCC || if_def.cursor !== 2'd0)
      begin bad++; $display("FAIL coinc_back_idle got=%0d/%h/%0d want=0/cccc/0", if_def.state, if_def.disp, if_def.cursor); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    enter_code(4, 32'h1234);
    repeat (3) press(1'b0, 1'b0, 1'b1, 1'b0);
    total++; if (if_def.disp !== 16'h3000) begin bad++; $display("FAIL midrst_pre got=%h want=3000", if_def.disp); end
    @(negedge clk);
    rst = 1'b1; bn = 1'b1; bu = 1'b1;
    @(negedge clk);
    total++; if (if_def.state !== 3'(IDLE) || if_def.disp !== 16'hCCCC || if_def.cursor !== 2'd0 || if_def.cursor_valid !== 1'b0)
      begin bad++; $display("FAIL midrst_state got=%0d/%h/%0d want=0/cccc/0", if_def.state, if_def.disp, if_def.cursor); end
    total++; if ({if_def.hits, if_def.blows, if_def.tries, 3'b000, if_def.flash} !== 16'h0000)
      begin bad++; $display("FAIL midrst_score got=%0d/%0d/%0d/%b want=0", if_def.hits, if_def.blows, if_def.tries, if_def.flash); end
    rst = 1'b0; bn = 1'b0; bu = 1'b0;
  endtask

  task automatic test_wide();
    do_reset();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (if_wide.cursor !== 3'd5) begin bad++; $display("FAIL wide_cursor got=%0d want=5", if_wide.cursor); end
    enter_code(6, 32'h123456);
    enter_code(6, 32'h213456);
    total++; if (if_wide.state !== 3'(RESULT) || if_wide.hits !== 4'd4 || if_wide.blows !== 4'd2 || if_wide.tries !== 4'd1)
      begin bad++; $display("FAIL wide_score got=%0d/%0d/%0d/%0d want=3/4/2/1", if_wide.state, if_wide.hits, if_wide.blows, if_wide.tries); end
    total++; if (if_wide.disp !== 24'h4A2BCC) begin bad++; $display("FAIL wide_disp got=%h want=4a2bcc", if_wide.disp); end
  endtask

  initial begin
    test_reset();
    test_win();
    test_result();
    test_lose();
    test_edit_limits();
    test_coincident();
    test_reset_mid();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_guess_core.md
# code_guess_core

Parametrised hits/blows code-guessing game engine. It runs the game state machine, digit editing, secret storage, scoring, attempt limiting and win flashing. Button inputs arrive already debounced and one-pulsed. The per-position display codes it produces feed the existing seven-segment scanner, and `flash` drives the LED bank.

## Interface
- `N_DIGITS`, default 4: code length; legal range 4..8.
- `RADIX`, default 10: digit values 0..RADIX-1; legal range 2..10.
- `MAX_TRIES`, default 8: guesses allowed before loss; 0 means unlimited.
- `WRAP`, default 0: 0 = up/down saturate; 1 = up/down wrap modulo RADIX.
- `FLASH_TICKS`, default 5: `tick` pulses spent in WIN before returning to IDLE.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `tick` in 1: one-cycle ~1 s strobe.
- `btn_next`, `btn_back`, `btn_up`, `btn_down` in 1 each: one-cycle pulses.
- `disp` out 4*N_DIGITS: display code per position; position 0 is in bits [3:0] and is the rightmost digit.
- `cursor` out clog2(N_DIGITS): index of the position being edited.
- `cursor_valid` out 1: high in SET and GUESS.
- `state` out 3: current state code.
- `hits`, `blows` out 4 each: result of the last scored guess.
- `tries` out 4: number of guesses scored this game.
- `flash` out 1: LED flash level.

## Operation
- Display codes: 0..9 are digits; 10 = 'A'; 11 = 'b'; 12 = dash.
- Button priority when pulses coincide: next > back > up > down. Only the highest-priority pulse acts.
- IDLE: all positions show dash. `btn_next` zeroes all digits, sets cursor to N_DIGITS-1 and enters SET.
- Editing, in both SET and GUESS:
  - `btn_up` / `btn_down` change the digit at `cursor`.
  - WRAP=0: the digit saturates at 0 and RADIX-1.
  - WRAP=1: RADIX-1+1 wraps to 0; 0-1 wraps to RADIX-1.
  - `btn_next` with cursor>0 decrements cursor.
  - `btn_back` with cursor<N_DIGITS-1 increments cursor.
  - `btn_back` with cursor==N_DIGITS-1 goes to IDLE.
- SET commit: `btn_next` with cursor==0 latches the secret. It then zeroes the digits, sets cursor to N_DIGITS-1, clears tries and enters GUESS.
- GUESS commit: `btn_next` with cursor==0 scores the guess and increments tries.
  - hits = count of positions i with guess[i]==secret[i].
  - blows = count of positions i with guess[i]!=secret[i] and guess[i]==secret[j] for some j!=i.
  - If hits==N_DIGITS, enter WIN.
  - Else, if MAX_TRIES!=0 and the new tries==MAX_TRIES, enter LOSE.
  - Otherwise enter RESULT.
- RESULT display: position N-1 = hits, N-2 = 'A', N-3 = blows, N-4 = 'b'; remaining positions show dash.
  - `btn_next` zeroes the digits, sets cursor to N_DIGITS-1 and enters GUESS.
  - `btn_back` goes to IDLE.
- WIN: the display holds the guess. `flash` toggles on each `tick`. After FLASH_TICKS ticks, go to IDLE with `flash` low. All buttons are ignored.
- LOSE: the display shows the secret. `btn_next` or `btn_back` goes to IDLE.
- Entering IDLE from any state clears hits, blows, tries, cursor and flash.

## Timing
- Reset values: state=IDLE, `disp` = all dash (12), cursor=0, cursor_valid=0, hits=0, blows=0, tries=0, flash=0. The secret is cleared to 0.
- Reset takes effect from any state, including mid-edit, in WIN, or on a cycle with a button pulse present; reset wins.
- All outputs are registered and respond in the cycle after the pulse or tick. No combinational path from inputs to outputs.
- Scoring is combinational on the current guess and secret, and is captured on the commit edge. hits, blows and tries are valid the following cycle and hold until the next commit or IDLE.
- The WIN tick counter counts only in WIN and clears on WIN entry. A tick in the same cycle as WIN entry is not counted.
- `tick` is ignored in every other state.

## Structure
- Package `guess_pkg` holds:
  - the state enum: IDLE=0, SET=1, GUESS=2, RESULT=3, WIN=4, LOSE=5;
  - the symbol constants SYM_A=10, SYM_B=11, SYM_DASH=12;
  - the 4-bit digit typedef.
- Sub-module `guess_scorer`: purely combinational, parametrised by N_DIGITS. Inputs are the guess and secret buses; outputs are hits and blows.
- Debounce, one-pulse, tick generation and seven-segment scanning stay outside this block.

## Test plan
1. Defaults: set secret 1234 and guess 1234, with ticks every 20 cycles → WIN; `flash` toggles 5 times, then IDLE with all dashes.
2. Defaults: secret 1234, guess 4231 → RESULT with hits=2, blows=2, tries=1, disp={2,A,2,b}. `btn_next` → GUESS with zeroed digits and cursor=3.
3. MAX_TRIES=2: two wrong guesses → LOSE showing the secret, tries=2. `btn_back` → IDLE with tries=0.
4. Editing limits: WRAP=0, 12 `btn_up` pulses on one digit → digit 9. With WRAP=1 and RADIX=6, one `btn_down` from 0 → 5.
5. Coincident and illegal inputs: `btn_next` and `btn_up` in the same cycle in SET → only the cursor moves. `btn_back` at cursor=N-1 → IDLE.
6. Reset and width: assert `rst` mid-GUESS with a button pulse present → all reset values next cycle. Repeat test 2 with N_DIGITS=6 and secret 123456 against guess 213456 → hits=4, blows=2.
